// File: rtl/mips_cpu_pkg.sv
// Shared decode definitions for the MIPS CPU core: FSM state type,
// opcode/funct constants and instruction-class helpers.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_MULDIV = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LWR    = 6'h26;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_MTHI   = 6'h11;
    localparam logic [5:0] FN_MTLO   = 6'h13;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_LWR);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && (fn >= FN_MULT) && (fn <= FN_DIVU);
    endfunction

    // Unknown opcodes fall through as ALU-class writers.
    function automatic logic writes_reg(input logic [5:0] op,
                                        input logic [4:0] rt,
                                        input logic [5:0] fn);
        logic w_wr;
        w_wr = 1'b1;
        if (is_store(op))
            w_wr = 1'b0;
        else if (op == OP_J || (op >= OP_BEQ && op <= OP_BGTZ))
            w_wr = 1'b0;
        else if (op == OP_RTYPE && (fn == FN_JR || fn == FN_MTHI || fn == FN_MTLO))
            w_wr = 1'b0;
        else if (op == OP_REGIMM && rt != RT_BLTZAL && rt != RT_BGEZAL)
            w_wr = 1'b0;
        return w_wr;
    endfunction

endpackage

// File: rtl/mips_cpu_seq_ctrl.sv
// Multi-cycle sequencer: steps each instruction through fetch/exec/mem/wb,
// honours memory waitrequest and holds for the iterative mult/div unit.
module mips_cpu_seq_ctrl
    import mips_cpu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] ir_opcode,
    input  logic [4:0] ir_rt,
    input  logic [5:0] ir_funct,
    input  logic       pc_zero,
    input  logic       mem_waitrequest,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel_pc,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       hilo_start,
    output logic       hilo_busy,
    output logic       active
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_load;
    logic             w_store;
    logic             w_muldiv;
    logic             w_cnt_done;

    assign w_load     = is_load(ir_opcode);
    assign w_store    = is_store(ir_opcode);
    assign w_muldiv   = is_muldiv(ir_opcode, ir_funct);
    assign w_cnt_done = (r_cnt == CNT_LAST);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        case (r_state)
            S_FETCH: begin
                if (pc_zero)
                    w_next = S_HALT;
                else if (!mem_waitrequest)
                    w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_load || w_store)
                    w_next = S_MEM;
                else if (w_muldiv)
                    w_next = S_MULDIV;
                else
                    w_next = S_WB;
            end
            S_MEM: begin
                if (!mem_waitrequest)
                    w_next = w_load ? S_WB : S_FETCH;
            end
            S_WB:     w_next = S_FETCH;
            S_MULDIV: begin
                if (w_cnt_done)
                    w_next = S_FETCH;
                else
                    w_cnt_next = r_cnt + CNT_W'(1);
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Outputs are forced to their idle values while reset is held so no
    // strobe escapes in the reset cycle itself.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr_sel_pc = 1'b1;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        hilo_start  = 1'b0;
        hilo_busy   = 1'b0;
        active      = 1'b1;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    if (!pc_zero) begin
                        mem_read = 1'b1;
                        ir_write = !mem_waitrequest;
                    end
                end
                S_EXEC:   hilo_start = w_muldiv;
                S_MEM: begin
                    addr_sel_pc = 1'b0;
                    mem_read    = w_load;
                    mem_write   = !w_load;
                    pc_write    = !w_load && !mem_waitrequest;
                end
                S_WB: begin
                    pc_write  = 1'b1;
                    reg_write = writes_reg(ir_opcode, ir_rt, ir_funct);
                end
                S_MULDIV: begin
                    hilo_busy = 1'b1;
                    pc_write  = w_cnt_done;
                end
                S_HALT:   active = 1'b0;
                default:  active = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_seq_ctrl.sv
// Directed scoreboard bench for the multi-cycle sequencing controller.
module tb_mips_cpu_seq_ctrl;
    import mips_cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] ir_opcode;
    logic [4:0] ir_rt;
    logic [5:0] ir_funct;
    logic       pc_zero;
    logic       mem_waitrequest;
    logic       mem_read, mem_write, addr_sel_pc, ir_write, reg_write;
    logic       pc_write, hilo_start, hilo_busy, active;
    logic [8:0] obs;

    always #5 clk = ~clk;

    mips_cpu_seq_ctrl #(.MULDIV_CYCLES(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ir_opcode      (ir_opcode),
        .ir_rt          (ir_rt),
        .ir_funct       (ir_funct),
        .pc_zero        (pc_zero),
        .mem_waitrequest(mem_waitrequest),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .addr_sel_pc    (addr_sel_pc),
        .ir_write       (ir_write),
        .reg_write      (reg_write),
        .pc_write       (pc_write),
        .hilo_start     (hilo_start),
        .hilo_busy      (hilo_busy),
        .active         (active)
    );

    assign obs = {mem_read, mem_write, addr_sel_pc, ir_write, reg_write,
                  pc_write, hilo_start, hilo_busy, active};

    localparam logic [8:0] MR  = 9'h100;
    localparam logic [8:0] MW  = 9'h080;
    localparam logic [8:0] AS  = 9'h040;
    localparam logic [8:0] IW  = 9'h020;
    localparam logic [8:0] RW  = 9'h010;
    localparam logic [8:0] PW  = 9'h008;
    localparam logic [8:0] HS  = 9'h004;
    localparam logic [8:0] HB  = 9'h002;
    localparam logic [8:0] AC  = 9'h001;
    localparam logic [8:0] ALL = 9'h1FF;
    localparam logic [8:0] NA  = 9'h1BF;

    typedef struct {
        logic [8:0] exp;
        logic [8:0] care;
        string      tag;
    } sb_t;

    sb_t q[$];
    int  checks = 0;
    int  errors = 0;

    // {opcode, rt, funct, expected reg_write} for instructions retiring via WB
    localparam int NWB = 16;
    localparam logic [17:0] WBT [NWB] = '{
        {6'h00, 5'h00, 6'h21, 1'b1},
        {6'h04, 5'h00, 6'h00, 1'b0},
        {6'h07, 5'h00, 6'h00, 1'b0},
        {6'h02, 5'h00, 6'h00, 1'b0},
        {6'h03, 5'h00, 6'h00, 1'b1},
        {6'h00, 5'h00, 6'h08, 1'b0},
        {6'h00, 5'h00, 6'h11, 1'b0},
        {6'h00, 5'h00, 6'h13, 1'b0},
        {6'h00, 5'h00, 6'h12, 1'b1},
        {6'h00, 5'h00, 6'h1C, 1'b1},
        {6'h01, 5'h00, 6'h00, 1'b0},
        {6'h01, 5'h10, 6'h00, 1'b1},
        {6'h01, 5'h11, 6'h00, 1'b1},
        {6'h09, 5'h00, 6'h00, 1'b1},
        {6'h27, 5'h00, 6'h00, 1'b1},
        {6'h3F, 5'h00, 6'h00, 1'b1}
    };

    task automatic set_ir(input logic [5:0] op, input logic [4:0] rt, input logic [5:0] fn);
        ir_opcode = op;
        ir_rt     = rt;
        ir_funct  = fn;
    endtask

    task automatic cyc(input string tag, input logic rst, input logic pz, input logic wr,
                       input logic [8:0] exp, input logic [8:0] care);
        sb_t e;
        reset           = rst;
        pc_zero         = pz;
        mem_waitrequest = wr;
        e.exp  = exp;
        e.care = care;
        e.tag  = tag;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        checks++;
        assert ((obs & e.care) === (e.exp & e.care)) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", e.tag, obs & e.care, e.exp & e.care);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input state_e s);
        checks++;
        assert (dut.r_state === s) else begin
            errors++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, int'(dut.r_state), int'(s));
        end
    endtask

    task automatic chk_cnt_zero(input string tag);
        checks++;
        assert (dut.r_cnt === '0) else begin
            errors++;
            $error("FAIL %s cnt obs=%0d exp=0", tag, int'(dut.r_cnt));
        end
    endtask

    task automatic run_wb(input logic [5:0] op, input logic [4:0] rt, input logic [5:0] fn,
                          input logic rw);
        set_ir(op, rt, fn);
        cyc("wb_fetch", 1'b1, 1'b0, 1'b0, MR | AS | IW | AC, ALL);
        cyc("wb_exec",  1'b1, 1'b0, 1'b0, AC, NA);
        cyc("wb_wb",    1'b1, 1'b0, 1'b0, PW | AC | (rw ? RW : 9'h000), NA);
        chk_state("wb_done", S_FETCH);
    endtask

    task automatic run_mem(input logic [5:0] op, input logic ld, input int wf, input int wm);
        set_ir(op, 5'h00, 6'h00);
        for (int i = 0; i < wf; i++)
            cyc("mem_fetch_stall", 1'b1, 1'b0, 1'b1, MR | AS | AC, ALL);
        cyc("mem_fetch", 1'b1, 1'b0, 1'b0, MR | AS | IW | AC, ALL);
        cyc("mem_exec",  1'b1, 1'b0, 1'b0, AC, NA);
        for (int i = 0; i < wm; i++)
            cyc("mem_stall", 1'b1, 1'b0, 1'b1, (ld ? MR : MW) | AC, ALL);
        if (ld) begin
            cyc("mem_ld_done", 1'b1, 1'b0, 1'b0, MR | AC, ALL);
            cyc("mem_ld_wb",   1'b1, 1'b0, 1'b0, RW | PW | AC, NA);
        end else begin
            cyc("mem_st_done", 1'b1, 1'b0, 1'b0, MW | PW | AC, ALL);
        end
        chk_state("mem_done", S_FETCH);
    endtask

    task automatic run_muldiv(input logic [5:0] fn);
        set_ir(6'h00, 5'h00, fn);
        cyc("md_fetch", 1'b1, 1'b0, 1'b0, MR | AS | IW | AC, ALL);
        cyc("md_exec",  1'b1, 1'b0, 1'b0, HS | AC, NA);
        for (int i = 0; i < 31; i++)
            cyc("md_busy", 1'b1, 1'b0, 1'b0, HB | AC, NA);
        cyc("md_last", 1'b1, 1'b0, 1'b0, HB | PW | AC, NA);
        chk_state("md_done", S_FETCH);
        chk_cnt_zero("md_done_cnt");
    endtask

    initial begin
        reset = 1'b0;
        pc_zero = 1'b0;
        mem_waitrequest = 1'b0;
        set_ir(6'h00, 5'h00, 6'h21);
        @(posedge clk);
        #1;

        cyc("reset0", 1'b0, 1'b0, 1'b0, AS | AC, ALL);
        cyc("reset1", 1'b0, 1'b1, 1'b0, AS | AC, ALL);
        chk_state("reset_state", S_FETCH);
        chk_cnt_zero("reset_cnt");

        for (int i = 0; i < NWB; i++)
            run_wb(WBT[i][17:12], WBT[i][11:7], WBT[i][6:1], WBT[i][0]);

        run_mem(6'h23, 1'b1, 2, 2);
        run_mem(6'h20, 1'b1, 0, 0);
        run_mem(6'h26, 1'b1, 0, 1);
        run_mem(6'h2B, 1'b0, 0, 0);
        run_mem(6'h28, 1'b0, 1, 2);
        run_mem(6'h29, 1'b0, 0, 0);

        run_muldiv(6'h18);
        run_muldiv(6'h1B);

        // reset mid mult/div iteration
        set_ir(6'h00, 5'h00, 6'h19);
        cyc("mdr_fetch", 1'b1, 1'b0, 1'b0, MR | AS | IW | AC, ALL);
        cyc("mdr_exec",  1'b1, 1'b0, 1'b0, HS | AC, NA);
        for (int i = 0; i < 9; i++)
            cyc("mdr_busy", 1'b1, 1'b0, 1'b0, HB | AC, NA);
        cyc("mdr_reset", 1'b0, 1'b0, 1'b0, AS | AC, ALL);
        chk_state("mdr_state", S_FETCH);
        chk_cnt_zero("mdr_cnt");

        // reset during a fetch stall
        set_ir(6'h00, 5'h00, 6'h21);
        cyc("fsr_stall", 1'b1, 1'b0, 1'b1, MR | AS | AC, ALL);
        cyc("fsr_reset", 1'b0, 1'b0, 1'b1, AS | AC, ALL);
        chk_state("fsr_state", S_FETCH);
        run_wb(6'h00, 5'h00, 6'h21, 1'b1);

        // halt on PC == 0, absorbing until reset
        cyc("halt_entry", 1'b1, 1'b1, 1'b0, AC, NA);
        chk_state("halt_state", S_HALT);
        for (int i = 0; i < 100; i++)
            cyc("halt_hold", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'h000, NA);
        chk_state("halt_still", S_HALT);
        cyc("halt_reset", 1'b0, 1'b0, 1'b0, AS | AC, ALL);
        chk_state("halt_exit", S_FETCH);
        run_wb(6'h00, 5'h00, 6'h21, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
